// File: rtl/wb_slave_bus_monitor.sv
// Passive Wishbone B4 pipelined-bus monitor.
// Counts requests and responses, checks the master and slave handshake rules
// on every clock, and records sticky fault flags together with the first
// violation code. It only observes the bus and never drives it.
module wb_slave_bus_monitor #(
    parameter int AW                   = 30,
    parameter int DW                   = 32,
    parameter int F_LGDEPTH            = 4,
    parameter int F_MAX_STALL          = 0,
    parameter int F_MAX_ACK_DELAY      = 0,
    parameter int F_MAX_REQUESTS       = 0,
    parameter int F_OPT_RMW_BUS_OPTION = 1,
    parameter int F_OPT_DISCONTINUOUS  = 1,
    parameter int F_OPT_MINCLOCK_DELAY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [AW-1:0]        i_wb_addr,
    input  logic [DW-1:0]        i_wb_data,
    input  logic [DW/8-1:0]      i_wb_sel,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_err,
    input  logic [DW-1:0]        i_wb_idata,
    output logic [F_LGDEPTH-1:0] f_nreqs,
    output logic [F_LGDEPTH-1:0] f_nacks,
    output logic [F_LGDEPTH-1:0] f_outstanding,
    output logic                 o_master_fault,
    output logic                 o_slave_fault,
    output logic [3:0]           o_fault_code
);

    // Stall and ack-delay timers saturate, so a wide enough fixed width is safe.
    localparam int TW = 16;
    localparam logic [TW-1:0]        MAX_STALL_T = TW'(F_MAX_STALL);
    localparam logic [TW-1:0]        MAX_DELAY_T = TW'(F_MAX_ACK_DELAY);
    localparam logic [F_LGDEPTH:0]   MAX_REQ_W   = (F_LGDEPTH+1)'(F_MAX_REQUESTS);
    localparam logic [F_LGDEPTH-1:0] CNT_MAX     = '1;

    logic [F_LGDEPTH-1:0] nreqs_q, nreqs_d, nacks_q, nacks_d;
    logic                 past_valid_q, past_valid_d;
    logic                 past_cyc_q, past_cyc_d;
    logic                 past_stb_q, past_stb_d;
    logic                 past_stall_q, past_stall_d;
    logic                 past_err_q, past_err_d;
    logic                 past_we_q, past_we_d;
    logic [AW-1:0]        past_addr_q, past_addr_d;
    logic [DW-1:0]        past_data_q, past_data_d;
    logic [DW/8-1:0]      past_sel_q, past_sel_d;
    logic                 cyc_we_q, cyc_we_d;
    logic                 cyc_we_valid_q, cyc_we_valid_d;
    logic                 stb_seen_q, stb_seen_d;
    logic                 stb_dropped_q, stb_dropped_d;
    logic                 idle_q, idle_d;
    logic [TW-1:0]        stall_cnt_q, stall_cnt_d;
    logic [TW-1:0]        delay_cnt_q, delay_cnt_d;
    logic                 master_fault_q, master_fault_d;
    logic                 slave_fault_q, slave_fault_d;
    logic [3:0]           fault_code_q, fault_code_d;

    logic                 req, resp, stalled, idle_now, waiting;
    logic [F_LGDEPTH:0]   nreqs_next_w;
    logic [15:1]          viol, viol_m;
    logic [3:0]           first_code;
    logic                 unused_idata;

    // Read data carries no protocol information for this monitor.
    assign unused_idata  = ^i_wb_idata;
    assign f_outstanding = nreqs_q - nacks_q;

    // Counters, history of the previous clock and the rule checks.
    always_comb begin
        req          = i_wb_cyc & i_wb_stb & ~i_wb_stall;
        resp         = i_wb_cyc & (i_wb_ack | i_wb_err);
        stalled      = i_wb_cyc & i_wb_stb & i_wb_stall;
        idle_now     = i_wb_cyc & ~i_wb_stb & (f_outstanding == '0);
        waiting      = (f_outstanding != '0) & ~resp;
        nreqs_next_w = {1'b0, nreqs_q} + (F_LGDEPTH+1)'(req);

        // An error or a dropped cycle abandons all pending transfers.
        if (!i_wb_cyc || i_wb_err) begin
            nreqs_d = '0;
            nacks_d = '0;
        end else begin
            nreqs_d = nreqs_q + F_LGDEPTH'(req);
            nacks_d = nacks_q + F_LGDEPTH'(resp);
        end

        past_valid_d = 1'b1;
        past_cyc_d   = i_wb_cyc;
        past_stb_d   = i_wb_stb;
        past_stall_d = i_wb_stall;
        past_err_d   = i_wb_err;
        past_we_d    = i_wb_we;
        past_addr_d  = i_wb_addr;
        past_data_d  = i_wb_data;
        past_sel_d   = i_wb_sel;

        cyc_we_valid_d = i_wb_cyc & (cyc_we_valid_q | i_wb_stb);
        cyc_we_d       = (i_wb_cyc & i_wb_stb) ? i_wb_we : cyc_we_q;
        stb_seen_d     = i_wb_cyc & (stb_seen_q | i_wb_stb);
        stb_dropped_d  = i_wb_cyc & (stb_dropped_q | (stb_seen_q & ~i_wb_stb));
        idle_d         = idle_now;

        if (!stalled)
            stall_cnt_d = '0;
        else if (stall_cnt_q == '1)
            stall_cnt_d = stall_cnt_q;
        else
            stall_cnt_d = stall_cnt_q + 1'b1;

        if (!waiting)
            delay_cnt_d = '0;
        else if (delay_cnt_q == '1)
            delay_cnt_d = delay_cnt_q;
        else
            delay_cnt_d = delay_cnt_q + 1'b1;

        viol     = '0;
        viol[1]  = i_wb_stb & ~i_wb_cyc;
        viol[2]  = past_cyc_q & past_stb_q & past_stall_q & i_wb_cyc & ~i_wb_stb;
        viol[3]  = past_cyc_q & past_stb_q & past_stall_q & i_wb_cyc & i_wb_stb &
                   ((i_wb_addr != past_addr_q) || (i_wb_we != past_we_q) ||
                    (i_wb_sel != past_sel_q) || (i_wb_we && (i_wb_data != past_data_q)));
        viol[4]  = i_wb_cyc & i_wb_stb & cyc_we_valid_q & (i_wb_we != cyc_we_q);
        viol[5]  = (F_OPT_DISCONTINUOUS == 0) & i_wb_cyc & i_wb_stb & stb_dropped_q;
        viol[6]  = (F_MAX_REQUESTS != 0) & req & (nreqs_next_w > MAX_REQ_W);
        viol[7]  = (req & (nreqs_q == CNT_MAX)) | (resp & (nacks_q == CNT_MAX));
        viol[8]  = past_cyc_q & past_err_q & i_wb_cyc;
        viol[9]  = (F_OPT_RMW_BUS_OPTION == 0) & idle_now & idle_q;
        viol[10] = i_wb_ack & i_wb_err;
        viol[11] = (i_wb_ack | i_wb_err) & ~i_wb_cyc & ~past_cyc_q;
        viol[12] = resp & (f_outstanding == '0) & ((F_OPT_MINCLOCK_DELAY != 0) | ~req);
        viol[13] = (F_MAX_STALL != 0) & stalled & (stall_cnt_q >= MAX_STALL_T);
        viol[14] = (F_MAX_ACK_DELAY != 0) & waiting & (delay_cnt_q >= MAX_DELAY_T);
        viol[15] = nacks_q > nreqs_q;

        // Nothing is checked on the first clock after reset: history is invalid.
        viol_m = past_valid_q ? viol : '0;

        first_code = 4'd0;
        for (int i = 15; i >= 1; i--) begin
            if (viol_m[i])
                first_code = 4'(i);
        end

        master_fault_d = master_fault_q | (|viol_m[9:1]);
        slave_fault_d  = slave_fault_q  | (|viol_m[15:10]);
        fault_code_d   = fault_code_q;
        if (!master_fault_q && !slave_fault_q && (|viol_m))
            fault_code_d = first_code;
    end

    // All monitor state; reset wipes everything, aborting any open bus cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            nreqs_q        <= '0;
            nacks_q        <= '0;
            past_valid_q   <= 1'b0;
            past_cyc_q     <= 1'b0;
            past_stb_q     <= 1'b0;
            past_stall_q   <= 1'b0;
            past_err_q     <= 1'b0;
            past_we_q      <= 1'b0;
            past_addr_q    <= '0;
            past_data_q    <= '0;
            past_sel_q     <= '0;
            cyc_we_q       <= 1'b0;
            cyc_we_valid_q <= 1'b0;
            stb_seen_q     <= 1'b0;
            stb_dropped_q  <= 1'b0;
            idle_q         <= 1'b0;
            stall_cnt_q    <= '0;
            delay_cnt_q    <= '0;
            master_fault_q <= 1'b0;
            slave_fault_q  <= 1'b0;
            fault_code_q   <= 4'd0;
        end else begin
            nreqs_q        <= nreqs_d;
            nacks_q        <= nacks_d;
            past_valid_q   <= past_valid_d;
            past_cyc_q     <= past_cyc_d;
            past_stb_q     <= past_stb_d;
            past_stall_q   <= past_stall_d;
            past_err_q     <= past_err_d;
            past_we_q      <= past_we_d;
            past_addr_q    <= past_addr_d;
            past_data_q    <= past_data_d;
            past_sel_q     <= past_sel_d;
            cyc_we_q       <= cyc_we_d;
            cyc_we_valid_q <= cyc_we_valid_d;
            stb_seen_q     <= stb_seen_d;
            stb_dropped_q  <= stb_dropped_d;
            idle_q         <= idle_d;
            stall_cnt_q    <= stall_cnt_d;
            delay_cnt_q    <= delay_cnt_d;
            master_fault_q <= master_fault_d;
            slave_fault_q  <= slave_fault_d;
            fault_code_q   <= fault_code_d;
        end
    end

    assign f_nreqs        = nreqs_q;
    assign f_nacks        = nacks_q;
    assign o_master_fault = master_fault_q;
    assign o_slave_fault  = slave_fault_q;
    assign o_fault_code   = fault_code_q;

endmodule

// File: tb/tb_wb_slave_bus_monitor.sv
// Directed bench for wb_slave_bus_monitor: a per-clock vector table plus
// hand-written sequences for the ack-delay timer, counter wrap and async reset.
module tb_wb_slave_bus_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] data = '0;
    logic [3:0]  sel = 4'hF;
    logic        ack = 1'b0, stall = 1'b0, err = 1'b0;
    logic [31:0] idata = 32'h0;

    logic [3:0] nreqs, nacks, outst, code;
    logic       mf, sf;
    logic [3:0] d_nreqs, d_nacks, d_outst, d_code;
    logic       d_mf, d_sf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_slave_bus_monitor dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
        .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_err(err), .i_wb_idata(idata),
        .f_nreqs(nreqs), .f_nacks(nacks), .f_outstanding(outst),
        .o_master_fault(mf), .o_slave_fault(sf), .o_fault_code(code)
    );

    wb_slave_bus_monitor #(.F_MAX_ACK_DELAY(2)) dut_d (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel),
        .i_wb_ack(ack), .i_wb_stall(stall), .i_wb_err(err), .i_wb_idata(idata),
        .f_nreqs(d_nreqs), .f_nacks(d_nacks), .f_outstanding(d_outst),
        .o_master_fault(d_mf), .o_slave_fault(d_sf), .o_fault_code(d_code)
    );

    typedef struct {
        logic       rst, cyc, stb, we;
        logic [29:0] addr;
        logic       ack, stall, err;
        logic [3:0] e_nreqs, e_nacks, e_out;
        logic       e_mf, e_sf;
        logic [3:0] e_code;
    } vec_t;

    vec_t vecs[24];

    function automatic vec_t mk(input logic r, c, s, w, input logic [29:0] a,
                                input logic k, st, e, input logic [3:0] en, ea, eo,
                                input logic emf, esf, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.cyc = c; v.stb = s; v.we = w; v.addr = a;
        v.ack = k; v.stall = st; v.err = e;
        v.e_nreqs = en; v.e_nacks = ea; v.e_out = eo;
        v.e_mf = emf; v.e_sf = esf; v.e_code = ec;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_main(input string tag, input logic [3:0] en, ea, eo,
                            input logic emf, esf, input logic [3:0] ec);
        chk({tag, " nreqs"}, int'(nreqs), int'(en));
        chk({tag, " nacks"}, int'(nacks), int'(ea));
        chk({tag, " outstanding"}, int'(outst), int'(eo));
        chk({tag, " master_fault"}, int'(mf), int'(emf));
        chk({tag, " slave_fault"}, int'(sf), int'(esf));
        chk({tag, " code"}, int'(code), int'(ec));
    endtask

    // Drive one clock of stimulus at the falling edge; return just after the rising edge.
    task automatic step(input logic r, c, s, w, input logic [29:0] a,
                        input logic k, st, e);
        @(negedge clk);
        rst = r; cyc = c; stb = s; we = w; addr = a;
        data = 32'hA500_0000 | {2'b00, a};
        ack = k; stall = st; err = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //              rst cyc stb we addr ack stl err | nrq nak out mf sf code
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        // single read, ack one clock later
        vecs[2]  = mk(0, 1, 1, 0, 0, 0, 0, 0,  1, 0,  1, 0, 0,  0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 1, 0, 0,  1, 1,  0, 0, 0,  0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        // three pipelined writes, request and ack in the same clock
        vecs[5]  = mk(0, 1, 1, 1, 1, 0, 0, 0,  1, 0,  1, 0, 0,  0);
        vecs[6]  = mk(0, 1, 1, 1, 2, 1, 0, 0,  2, 1,  1, 0, 0,  0);
        vecs[7]  = mk(0, 1, 1, 1, 3, 1, 0, 0,  3, 2,  1, 0, 0,  0);
        vecs[8]  = mk(0, 1, 0, 1, 3, 1, 0, 0,  3, 3,  0, 0, 0,  0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        // address changes while stalled
        vecs[10] = mk(0, 1, 1, 0, 0, 0, 1, 0,  0, 0,  0, 0, 0,  0);
        vecs[11] = mk(0, 1, 1, 0, 1, 0, 1, 0,  0, 0,  0, 1, 0,  3);
        vecs[12] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        // ack with nothing outstanding; outstanding goes to 0-1 = 15
        vecs[14] = mk(0, 1, 0, 0, 0, 1, 0, 0,  0, 1, 15, 0, 1, 12);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        // ack and err together; err clears the counters
        vecs[17] = mk(0, 1, 0, 0, 0, 1, 0, 1,  0, 0,  0, 0, 1, 10);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        // stb without cyc: ignored on the first clock after reset, caught on the next
        vecs[19] = mk(0, 0, 1, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        vecs[20] = mk(0, 0, 1, 0, 0, 0, 0, 0,  0, 0,  0, 1, 0,  1);
        // later slave fault ORs its flag but keeps the first code
        vecs[21] = mk(0, 0, 0, 0, 0, 1, 0, 1,  0, 0,  0, 1, 1,  1);
        vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0,  0, 0, 0,  0);

        for (int i = 0; i < 24; i++) begin
            step(vecs[i].rst, vecs[i].cyc, vecs[i].stb, vecs[i].we, vecs[i].addr,
                 vecs[i].ack, vecs[i].stall, vecs[i].err);
            chk_main($sformatf("vec%0d", i), vecs[i].e_nreqs, vecs[i].e_nacks,
                     vecs[i].e_out, vecs[i].e_mf, vecs[i].e_sf, vecs[i].e_code);
        end

        // Ack-delay limit of 2: the third unanswered clock faults with code 14.
        step(0, 1, 1, 0, 0, 0, 0, 0);
        chk("delay d_nreqs", int'(d_nreqs), 1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("delay 2 clocks d_slave_fault", int'(d_sf), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("delay 3 clocks d_slave_fault", int'(d_sf), 1);
        chk("delay 3 clocks d_code", int'(d_code), 14);
        chk("delay unchecked slave_fault", int'(sf), 0);
        chk("delay unchecked code", int'(code), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("reset d_slave_fault", int'(d_sf), 0);
        chk("reset d_code", int'(d_code), 0);
        chk("reset d_nreqs", int'(d_nreqs), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Request counter wrap: 15 requests fit, the 16th faults with code 7.
        for (int i = 0; i < 15; i++)
            step(0, 1, 1, 0, 30'(i), 0, 0, 0);
        chk("wrap 15 nreqs", int'(nreqs), 15);
        chk("wrap 15 master_fault", int'(mf), 0);
        step(0, 1, 1, 0, 30'd15, 0, 0, 0);
        chk("wrap 16 master_fault", int'(mf), 1);
        chk("wrap 16 code", int'(code), 7);

        // Asynchronous reset in the middle of an open cycle.
        step(0, 1, 1, 0, 30'd16, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst nreqs", int'(nreqs), 0);
        chk("async rst master_fault", int'(mf), 0);
        chk("async rst code", int'(code), 0);
        chk("async rst d_code", int'(d_code), 0);
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk_main("post abort", 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
